// File: rtl/bcd_pkg.sv
// Packed-BCD price type shared by the order-book blocks.
package bcd_pkg;

  localparam int unsigned PRICE_DIGITS = 4;
  localparam int unsigned PRICE_BITS   = 4 * PRICE_DIGITS;

  // Most significant digit in the top nibble, so unsigned compare orders by value.
  typedef logic [PRICE_BITS-1:0] price_t;

endpackage

// File: rtl/ob_pkg.sv
// Order-book shared types: table entry, response status, accumulator and table ops.
package ob_pkg;

  import bcd_pkg::*;

  localparam int unsigned UID_BITS                  = 8;
  localparam int unsigned TABLE_QUANTITY_BITS       = 16;
  localparam int unsigned ACCUM_TABLE_QUANTITY_BITS = 32;

  typedef logic [UID_BITS-1:0]                  uid_t;
  typedef logic [TABLE_QUANTITY_BITS-1:0]       quantity_t;
  typedef logic [ACCUM_TABLE_QUANTITY_BITS-1:0] accum_quantity_t;

  typedef struct packed {
    uid_t      uid;
    quantity_t quantity;
    price_t    price;
  } table_t;

  typedef enum logic [2:0] {
    S_Okay,
    S_Reject,
    S_BadPop,
    S_CancelHit,
    S_CancelMiss
  } status_t;

  // Idle head values: worst possible price for each side, reserved uid.
  localparam table_t TABLE_BID_INIT = '{uid: {UID_BITS{1'b1}}, quantity: '0, price: '0};
  localparam table_t TABLE_ASK_INIT = '{uid: {UID_BITS{1'b1}}, quantity: '0,
                                        price: {PRICE_DIGITS{4'h9}}};

  typedef enum logic [1:0] {
    Tbl_Insert,
    Tbl_Pop,
    Tbl_Cancel,
    Tbl_Qry
  } tbl_op_t;

endpackage

// File: rtl/ob_lmt_tbl_cmp.sv
// Price ordering: better = a strictly ahead of b for this book side; equal = same price.
// Ports: a, b (prices) in; better, equal out (combinational).
module ob_lmt_tbl_cmp
  import bcd_pkg::*;
#(
  parameter bit IS_BID = 1'b1
) (
  input  price_t a,
  input  price_t b,
  output logic   better,
  output logic   equal
);

  always_comb begin
    equal  = (a == b);
    better = IS_BID ? (a > b) : (a < b);
  end

endmodule

// File: rtl/ob_lmt_tbl.sv
// Price/time-priority limit table: sorted slots, insert/pop/cancel in one cycle,
// quantity query scanned one slot per cycle.
// Ports: clk/arst_n; command in_vld/in_rdy/in_op/in_entry; response rsp_vld/
// rsp_status/rsp_entry/rsp_accum; registered status head_vld/head/count/full/empty.
module ob_lmt_tbl
  import bcd_pkg::*;
  import ob_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter bit          IS_BID    = 1'b1,
  parameter bit          CANCEL_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  tbl_op_t                  in_op,
  input  table_t                   in_entry,
  output logic                     rsp_vld,
  output status_t                  rsp_status,
  output table_t                   rsp_entry,
  output accum_quantity_t          rsp_accum,
  output logic                     head_vld,
  output table_t                   head,
  output logic [$clog2(N+1)-1:0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned CW  = $clog2(N + 1);
  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned ACW = ACCUM_TABLE_QUANTITY_BITS;
  localparam table_t HEAD_INIT = IS_BID ? TABLE_BID_INIT : TABLE_ASK_INIT;

  typedef enum logic {IDLE, QRY} state_t;

  state_t          state_q, state_d;
  table_t          slot_q [N];
  table_t          slot_d [N];
  table_t          slot_prev [N];
  table_t          slot_next [N];
  logic [N-1:0]    vld_q, vld_d, vld_prev, vld_next;
  logic [N-1:0]    keep, keep_prev, hit, rm;
  table_t          hit_entry;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d, head_vld_q, head_vld_d;
  table_t          head_q, head_d;
  logic            rdy_q, rdy_d;
  logic [IW-1:0]   scan_q, scan_d;
  accum_quantity_t accum_q, accum_d, accum_sum;
  price_t          qry_price_q, qry_price_d;
  logic            rsp_vld_q, rsp_vld_d;
  status_t         rsp_status_q, rsp_status_d;
  table_t          rsp_entry_q, rsp_entry_d;
  accum_quantity_t rsp_accum_q, rsp_accum_d;
  table_t          scan_entry;
  logic            scan_better, scan_equal, scan_ok;
  logic            accept;

  assign accept = in_vld & rdy_q;

  // Per-slot compare against the incoming price, uid match, and shift sources.
  for (genvar i = 0; i < N; i++) begin : g_slot
    logic s_better, s_equal;
    ob_lmt_tbl_cmp #(.IS_BID(IS_BID)) u_cmp (
      .a      (slot_q[i].price),
      .b      (in_entry.price),
      .better (s_better),
      .equal  (s_equal)
    );
    // Slots at least as good as the new price stay put (FIFO among equal prices).
    assign keep[i] = vld_q[i] & (s_better | s_equal);
    assign hit[i]  = vld_q[i] & (slot_q[i].uid == in_entry.uid);
    if (i == 0) begin : g_first
      assign slot_prev[i] = in_entry;
    end else begin : g_rest
      assign slot_prev[i] = slot_q[i-1];
    end
    if (i == N - 1) begin : g_last
      assign slot_next[i] = slot_q[i];
    end else begin : g_inner
      assign slot_next[i] = slot_q[i+1];
    end
  end

  assign vld_prev  = {vld_q[N-2:0], 1'b0};
  assign vld_next  = {1'b0, vld_q[N-1:1]};
  assign keep_prev = {keep[N-2:0], 1'b1};

  // Lowest matching slot and the removal mask covering it and everything below.
  always_comb begin
    logic any;
    any       = 1'b0;
    rm        = '0;
    hit_entry = '0;
    for (int j = 0; j < N; j++) begin
      any   = any | hit[j];
      rm[j] = any;
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (hit[j]) hit_entry = slot_q[j];
    end
  end

  // Query scan path.
  assign scan_entry = slot_q[scan_q];
  ob_lmt_tbl_cmp #(.IS_BID(IS_BID)) u_qry_cmp (
    .a      (scan_entry.price),
    .b      (qry_price_q),
    .better (scan_better),
    .equal  (scan_equal)
  );
  assign scan_ok   = vld_q[scan_q] & (scan_better | scan_equal);
  assign accum_sum = accum_q + ACW'(scan_entry.quantity);

  // Next-state, table update and response.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    vld_d        = vld_q;
    count_d      = count_q;
    scan_d       = scan_q;
    accum_d      = accum_q;
    qry_price_d  = qry_price_q;
    rsp_vld_d    = 1'b0;
    rsp_status_d = S_Okay;
    rsp_entry_d  = '0;
    rsp_accum_d  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_vld_d = 1'b1;
          case (in_op)
            Tbl_Insert: begin
              if (full_q || (in_entry.quantity == '0) || (in_entry.uid == '1)) begin
                rsp_status_d = S_Reject;
              end else begin
                for (int j = 0; j < N; j++) begin
                  if (!keep[j]) begin
                    slot_d[j] = keep_prev[j] ? in_entry : slot_prev[j];
                    vld_d[j]  = keep_prev[j] | vld_prev[j];
                  end
                end
                count_d = count_q + CW'(1);
              end
            end
            Tbl_Pop: begin
              if (empty_q) begin
                rsp_status_d = S_BadPop;
              end else begin
                rsp_entry_d = slot_q[0];
                slot_d      = slot_next;
                vld_d       = vld_next;
                count_d     = count_q - CW'(1);
              end
            end
            Tbl_Cancel: begin
              if (CANCEL_EN && (|hit)) begin
                rsp_status_d = S_CancelHit;
                rsp_entry_d  = hit_entry;
                for (int j = 0; j < N; j++) begin
                  if (rm[j]) begin
                    slot_d[j] = slot_next[j];
                    vld_d[j]  = vld_next[j];
                  end
                end
                count_d = count_q - CW'(1);
              end else begin
                rsp_status_d = S_CancelMiss;
              end
            end
            Tbl_Qry: begin
              rsp_vld_d   = 1'b0;
              state_d     = QRY;
              scan_d      = '0;
              accum_d     = '0;
              qry_price_d = in_entry.price;
            end
            default: ;
          endcase
        end
      end
      QRY: begin
        if (scan_ok && (scan_q != IW'(N - 1))) begin
          accum_d = accum_sum;
          scan_d  = scan_q + IW'(1);
        end else begin
          rsp_vld_d   = 1'b1;
          rsp_accum_d = scan_ok ? accum_sum : accum_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    full_d     = (count_d == CW'(N));
    empty_d    = (count_d == '0);
    head_vld_d = vld_d[0];
    head_d     = vld_d[0] ? slot_d[0] : HEAD_INIT;
    rdy_d      = (state_d == IDLE);
  end

  // Control and valid-bit registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      vld_q        <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      head_vld_q   <= 1'b0;
      head_q       <= HEAD_INIT;
      rdy_q        <= 1'b0;
      scan_q       <= '0;
      accum_q      <= '0;
      qry_price_q  <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_status_q <= S_Okay;
      rsp_entry_q  <= '0;
      rsp_accum_q  <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      head_vld_q   <= head_vld_d;
      head_q       <= head_d;
      rdy_q        <= rdy_d;
      scan_q       <= scan_d;
      accum_q      <= accum_d;
      qry_price_q  <= qry_price_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_status_q <= rsp_status_d;
      rsp_entry_q  <= rsp_entry_d;
      rsp_accum_q  <= rsp_accum_d;
    end
  end

  // Slot payloads are qualified by vld_q, so they carry no reset.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign in_rdy     = rdy_q;
  assign rsp_vld    = rsp_vld_q;
  assign rsp_status = rsp_status_q;
  assign rsp_entry  = rsp_entry_q;
  assign rsp_accum  = rsp_accum_q;
  assign head_vld   = head_vld_q;
  assign head       = head_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_ob_lmt_tbl.sv
// Directed bench: bid N=4 (d=0), ask N=4 (d=1), bid N=8 (d=2) sharing command inputs.
module tb_ob_lmt_tbl;
  import bcd_pkg::*;
  import ob_pkg::*;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  tbl_op_t         in_op;
  table_t          in_entry;
  logic            vld [3];
  logic            rdy [3];
  logic            rv [3];
  status_t         rs [3];
  table_t          re [3];
  accum_quantity_t ra [3];
  logic            hv [3];
  table_t          hd [3];
  logic            full_s [3];
  logic            empty_s [3];
  logic [2:0]      cnt0, cnt1;
  logic [3:0]      cnt2;

  int vecs = 0;
  int errs = 0;

  ob_lmt_tbl #(.N(4), .IS_BID(1'b1), .CANCEL_EN(1'b1)) u_bid4 (
    .clk(clk), .arst_n(arst_n), .in_vld(vld[0]), .in_rdy(rdy[0]), .in_op(in_op),
    .in_entry(in_entry), .rsp_vld(rv[0]), .rsp_status(rs[0]), .rsp_entry(re[0]),
    .rsp_accum(ra[0]), .head_vld(hv[0]), .head(hd[0]), .count(cnt0),
    .full(full_s[0]), .empty(empty_s[0]));

  ob_lmt_tbl #(.N(4), .IS_BID(1'b0), .CANCEL_EN(1'b1)) u_ask4 (
    .clk(clk), .arst_n(arst_n), .in_vld(vld[1]), .in_rdy(rdy[1]), .in_op(in_op),
    .in_entry(in_entry), .rsp_vld(rv[1]), .rsp_status(rs[1]), .rsp_entry(re[1]),
    .rsp_accum(ra[1]), .head_vld(hv[1]), .head(hd[1]), .count(cnt1),
    .full(full_s[1]), .empty(empty_s[1]));

  ob_lmt_tbl #(.N(8), .IS_BID(1'b1), .CANCEL_EN(1'b1)) u_bid8 (
    .clk(clk), .arst_n(arst_n), .in_vld(vld[2]), .in_rdy(rdy[2]), .in_op(in_op),
    .in_entry(in_entry), .rsp_vld(rv[2]), .rsp_status(rs[2]), .rsp_entry(re[2]),
    .rsp_accum(ra[2]), .head_vld(hv[2]), .head(hd[2]), .count(cnt2),
    .full(full_s[2]), .empty(empty_s[2]));

  function automatic int cnt_of(input int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One command, accepted on the next rising edge; response sampled 1ns after it.
  task automatic cmd(input int d, input tbl_op_t op, input int uid, input int qty,
                     input logic [15:0] price, output logic v, output status_t st,
                     output table_t ent);
    @(negedge clk);
    in_op             = op;
    in_entry.uid      = uid_t'(uid);
    in_entry.quantity = quantity_t'(qty);
    in_entry.price    = price;
    vld[d]            = 1'b1;
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    v   = rv[d];
    st  = rs[d];
    ent = re[d];
  endtask

  // Query with bounded wait; lat counts edges from accept to visible response.
  task automatic qry(input int d, input logic [15:0] price, input int n,
                     output logic got_rsp, output accum_quantity_t acc, output int lat,
                     output logic rdy_seen);
    logic v;
    status_t st;
    table_t ent;
    cmd(d, Tbl_Qry, 0, 0, price, v, st, ent);
    lat      = 0;
    rdy_seen = rdy[d];
    got_rsp  = v;
    while (!got_rsp && lat <= n + 1) begin
      @(posedge clk);
      #1;
      lat++;
      got_rsp = rv[d];
      if (!got_rsp && rdy[d]) rdy_seen = 1'b1;
    end
    acc = ra[d];
    check("qry_status", 64'(rs[d]), 64'(S_Okay));
  endtask

  logic [15:0]     p28 [4] = '{16'h0100, 16'h0300, 16'h0200, 16'h0300};
  int              u28 [4] = '{2, 4, 3, 1};
  logic [15:0]     q28 [4] = '{16'h0300, 16'h0300, 16'h0200, 16'h0100};
  logic [15:0]     p29 [4] = '{16'h0500, 16'h0400, 16'h0600, 16'h0400};
  int              u29 [4] = '{14, 16, 11, 13};

  initial begin
    logic v, rdy_seen, saw;
    status_t st;
    table_t ent;
    accum_quantity_t acc;
    int lat;

    arst_n = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
    in_op    = Tbl_Insert;
    in_entry = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 64'(rdy[1]), 64'(0));
    check("rst_empty", 64'(empty_s[1]), 64'(1));
    check("rst_full", 64'(full_s[1]), 64'(0));
    check("rst_count", 64'(cnt_of(1)), 64'(0));
    check("rst_head_vld", 64'(hv[1]), 64'(0));
    check("rst_rsp_vld", 64'(rv[1]), 64'(0));
    check("rst_head_ask", 64'(hd[1]), 64'(TABLE_ASK_INIT));
    check("rst_head_bid", 64'(hd[0]), 64'(TABLE_BID_INIT));
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", 64'(rdy[0]), 64'(1));

    // Bid ordering with FIFO tie-break.
    for (int i = 0; i < 4; i++) begin
      cmd(0, Tbl_Insert, i + 1, 5, p28[i], v, st, ent);
      check("ins28_vld", 64'(v), 64'(1));
      check("ins28_st", 64'(st), 64'(S_Okay));
    end
    check("ins28_head_uid", 64'(hd[0].uid), 64'(2));
    check("ins28_full", 64'(full_s[0]), 64'(1));
    check("ins28_count", 64'(cnt_of(0)), 64'(4));
    for (int i = 0; i < 4; i++) begin
      cmd(0, Tbl_Pop, 0, 0, 16'h0, v, st, ent);
      check("pop28_st", 64'(st), 64'(S_Okay));
      check("pop28_uid", 64'(ent.uid), 64'(u28[i]));
      check("pop28_price", 64'(ent.price), 64'(q28[i]));
    end
    cmd(0, Tbl_Pop, 0, 0, 16'h0, v, st, ent);
    check("pop28_bad", 64'(st), 64'(S_BadPop));
    check("pop28_bad_ent", 64'(ent), 64'(0));
    check("pop28_empty", 64'(empty_s[0]), 64'(1));
    check("pop28_head", 64'(hd[0]), 64'(TABLE_BID_INIT));

    // Ask: full/zero-quantity/reserved-uid rejects, then ascending order.
    for (int i = 0; i < 4; i++) begin
      cmd(1, Tbl_Insert, 11 + i, 7, p29[i], v, st, ent);
      check("ins29_st", 64'(st), 64'(S_Okay));
    end
    check("ask_head_uid", 64'(hd[1].uid), 64'(12));
    cmd(1, Tbl_Insert, 9, 7, 16'h0100, v, st, ent);
    check("full_rej_st", 64'(st), 64'(S_Reject));
    check("full_rej_cnt", 64'(cnt_of(1)), 64'(4));
    check("full_rej_head", 64'(hd[1].uid), 64'(12));
    cmd(1, Tbl_Pop, 0, 0, 16'h0, v, st, ent);
    check("ask_pop_uid", 64'(ent.uid), 64'(12));
    cmd(1, Tbl_Insert, 15, 0, 16'h0100, v, st, ent);
    check("qty0_rej_st", 64'(st), 64'(S_Reject));
    check("qty0_rej_cnt", 64'(cnt_of(1)), 64'(3));
    cmd(1, Tbl_Insert, 255, 3, 16'h0100, v, st, ent);
    check("uid1s_rej_st", 64'(st), 64'(S_Reject));
    cmd(1, Tbl_Insert, 16, 1, 16'h0450, v, st, ent);
    check("ask_ins16_st", 64'(st), 64'(S_Okay));
    for (int i = 0; i < 4; i++) begin
      cmd(1, Tbl_Pop, 0, 0, 16'h0, v, st, ent);
      check("ask_pop_order", 64'(ent.uid), 64'(u29[i]));
    end

    // Cancel hit/miss.
    cmd(2, Tbl_Insert, 5, 1, 16'h0300, v, st, ent);
    cmd(2, Tbl_Insert, 6, 1, 16'h0200, v, st, ent);
    cmd(2, Tbl_Cancel, 6, 0, 16'h0, v, st, ent);
    check("cancel_hit_st", 64'(st), 64'(S_CancelHit));
    check("cancel_hit_ent", 64'(ent), 64'({8'd6, 16'd1, 16'h0200}));
    check("cancel_hit_cnt", 64'(cnt_of(2)), 64'(1));
    check("cancel_hit_head", 64'(hd[2].uid), 64'(5));
    cmd(2, Tbl_Cancel, 7, 0, 16'h0, v, st, ent);
    check("cancel_miss_st", 64'(st), 64'(S_CancelMiss));
    check("cancel_miss_ent", 64'(ent), 64'(0));
    check("cancel_miss_cnt", 64'(cnt_of(2)), 64'(1));
    cmd(2, Tbl_Pop, 0, 0, 16'h0, v, st, ent);
    check("cancel_pop_uid", 64'(ent.uid), 64'(5));

    // Query accumulation.
    cmd(2, Tbl_Insert, 31, 10, 16'h0300, v, st, ent);
    cmd(2, Tbl_Insert, 32, 20, 16'h0200, v, st, ent);
    cmd(2, Tbl_Insert, 33, 30, 16'h0100, v, st, ent);
    qry(2, 16'h0150, 8, v, acc, lat, rdy_seen);
    check("qry150_rsp", 64'(v), 64'(1));
    check("qry150_accum", 64'(acc), 64'(30));
    check("qry150_lat_ok", 64'(lat <= 9), 64'(1));
    check("qry150_rdy_low", 64'(rdy_seen), 64'(0));
    check("qry150_ent", 64'(re[2]), 64'(0));
    qry(2, 16'h0300, 8, v, acc, lat, rdy_seen);
    check("qry300_accum", 64'(acc), 64'(10));
    qry(2, 16'h0000, 8, v, acc, lat, rdy_seen);
    check("qry000_accum", 64'(acc), 64'(60));
    qry(2, 16'h0400, 8, v, acc, lat, rdy_seen);
    check("qry400_rsp", 64'(v), 64'(1));
    check("qry400_accum", 64'(acc), 64'(0));

    // Back-to-back Insert, Pop, Insert.
    @(negedge clk);
    in_op = Tbl_Insert; in_entry = '{uid: 8'd21, quantity: 16'd2, price: 16'h0250};
    vld[0] = 1'b1;
    @(posedge clk); #1;
    check("b2b1_vld", 64'(rv[0]), 64'(1));
    check("b2b1_st", 64'(rs[0]), 64'(S_Okay));
    check("b2b1_head", 64'(hd[0].uid), 64'(21));
    check("b2b1_rdy", 64'(rdy[0]), 64'(1));
    @(negedge clk);
    in_op = Tbl_Pop;
    @(posedge clk); #1;
    check("b2b2_vld", 64'(rv[0]), 64'(1));
    check("b2b2_ent", 64'(re[0].uid), 64'(21));
    check("b2b2_head_vld", 64'(hv[0]), 64'(0));
    @(negedge clk);
    in_op = Tbl_Insert; in_entry = '{uid: 8'd22, quantity: 16'd4, price: 16'h0120};
    @(posedge clk); #1;
    check("b2b3_vld", 64'(rv[0]), 64'(1));
    check("b2b3_st", 64'(rs[0]), 64'(S_Okay));
    check("b2b3_head", 64'(hd[0].uid), 64'(22));
    @(negedge clk);
    vld[0] = 1'b0;

    // Reset mid-query aborts without a response.
    @(negedge clk);
    in_op = Tbl_Qry; in_entry = '{uid: 8'd0, quantity: 16'd0, price: 16'h0000};
    vld[2] = 1'b1;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    saw = rv[2];
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    saw = saw | rv[2];
    check("midq_rst_rdy", 64'(rdy[2]), 64'(0));
    repeat (2) begin
      @(posedge clk); #1;
      saw = saw | rv[2];
    end
    @(negedge clk);
    arst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      saw = saw | rv[2];
    end
    check("midq_no_rsp", 64'(saw), 64'(0));
    check("midq_empty", 64'(empty_s[2]), 64'(1));
    check("midq_count", 64'(cnt_of(2)), 64'(0));
    check("midq_head_vld", 64'(hv[2]), 64'(0));
    check("midq_rdy", 64'(rdy[2]), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
